// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS-subset control FSM driving PC/IR/regfile/extender/ALU/memory.
// Define MC_CTRL_JAL_EN to decode jal (opcode 000011) as jump-and-link.
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_wr,
  output logic [1:0] npc_sel,
  output logic       ir_wr,
  output logic [1:0] eop,
  output logic [1:0] alu_op,
  output logic       alu_srcb,
  output logic       reg_wr,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       instr_done,
  output logic       illegal
);
  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXE, S_MEM, S_WB, S_BRANCH, S_JUMP
  } state_t;
  typedef enum logic [3:0] {
    C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL
  } cls_t;
  state_t     r_state, w_next;
  cls_t       r_cls, w_cls;
  logic [1:0] w_xeop;
  logic       w_xsrcb, w_ls;
  always_comb begin
    w_cls = C_ILL;
    case (opcode)
      6'b000000: w_cls = funct == 6'b100001 ? C_ADDU : funct == 6'b100011 ? C_SUBU : C_ILL;
      6'b001101: w_cls = C_ORI;
      6'b001111: w_cls = C_LUI;
      6'b100011: w_cls = C_LW;
      6'b101011: w_cls = C_SW;
      6'b000100: w_cls = C_BEQ;
      6'b000010: w_cls = C_J;
`ifdef MC_CTRL_JAL_EN
      6'b000011: w_cls = C_JAL;
`endif
      default:   w_cls = C_ILL;
    endcase
  end
  // Extender/operand-B choice is set in EXE and held through MEM/WB
  assign w_xeop  = r_cls == C_LUI ? 2'd2 : (r_cls == C_LW || r_cls == C_SW) ? 2'd1 : 2'd0;
  assign w_xsrcb = r_cls == C_ORI || r_cls == C_LUI || r_cls == C_LW || r_cls == C_SW;
  assign w_ls    = r_cls == C_LW || r_cls == C_SW;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_RST;
      r_cls   <= C_ILL;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_cls <= w_cls;
    end
  end
  always_comb begin
    w_next     = r_state;
    pc_wr      = 1'b0;
    npc_sel    = 2'd0;
    ir_wr      = 1'b0;
    eop        = 2'd0;
    alu_op     = 2'd0;
    alu_srcb   = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 2'd0;
    wd_sel     = 2'd0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      S_RST: w_next = S_FETCH;
      S_FETCH: begin
        ir_wr  = 1'b1;
        pc_wr  = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        eop     = 2'd3;
        illegal = w_cls == C_ILL;
        w_next  = w_cls == C_ILL ? S_FETCH :
                  w_cls == C_BEQ ? S_BRANCH :
                  (w_cls == C_J || w_cls == C_JAL) ? S_JUMP : S_EXE;
      end
      S_EXE: begin
        eop      = w_xeop;
        alu_srcb = w_xsrcb;
        alu_op   = r_cls == C_SUBU ? 2'd1 : (r_cls == C_ORI || r_cls == C_LUI) ? 2'd2 : 2'd0;
        w_next   = w_ls ? S_MEM : S_WB;
      end
      S_MEM: begin
        eop        = w_xeop;
        alu_srcb   = w_xsrcb;
        mem_rd     = r_cls == C_LW;
        mem_wr     = r_cls == C_SW;
        instr_done = mem_ready && r_cls == C_SW;
        w_next     = !mem_ready ? S_MEM : r_cls == C_LW ? S_WB : S_FETCH;
      end
      S_WB: begin
        eop        = w_xeop;
        alu_srcb   = w_xsrcb;
        reg_wr     = 1'b1;
        instr_done = 1'b1;
        reg_dst    = (r_cls == C_ADDU || r_cls == C_SUBU) ? 2'd1 : 2'd0;
        wd_sel     = r_cls == C_LW ? 2'd1 : 2'd0;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        alu_op     = 2'd1;
        npc_sel    = 2'd1;
        pc_wr      = zero;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        npc_sel    = 2'd2;
        pc_wr      = 1'b1;
        instr_done = 1'b1;
`ifdef MC_CTRL_JAL_EN
        reg_wr     = r_cls == C_JAL;
        reg_dst    = r_cls == C_JAL ? 2'd2 : 2'd0;
        wd_sel     = r_cls == C_JAL ? 2'd2 : 2'd0;
`endif
        w_next     = S_FETCH;
      end
      default: w_next = S_RST;
    endcase
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed plan items plus random instruction stream against a per-instruction cycle model.
module tb_mc_ctrl;
  typedef struct packed {
    logic       pc_wr;
    logic [1:0] npc_sel;
    logic       ir_wr;
    logic [1:0] eop;
    logic [1:0] alu_op;
    logic       alu_srcb;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       mem_rd;
    logic       mem_wr;
    logic       instr_done;
    logic       illegal;
  } out_t;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       pc_wr, ir_wr, alu_srcb, reg_wr, mem_rd, mem_wr, instr_done, illegal;
  logic [1:0] npc_sel, eop, alu_op, reg_dst, wd_sel;
  out_t       act;
  int         checks = 0, errors = 0;
  mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_wr(pc_wr), .npc_sel(npc_sel), .ir_wr(ir_wr),
    .eop(eop), .alu_op(alu_op), .alu_srcb(alu_srcb), .reg_wr(reg_wr),
    .reg_dst(reg_dst), .wd_sel(wd_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .instr_done(instr_done), .illegal(illegal)
  );
  always #5 clk = ~clk;
  assign act = {pc_wr, npc_sel, ir_wr, eop, alu_op, alu_srcb, reg_wr, reg_dst,
                wd_sel, mem_rd, mem_wr, instr_done, illegal};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // 0 addu 1 subu 2 ori 3 lui 4 lw 5 sw 6 beq 7 j 8 jal 9 illegal
  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000000 && fn == 6'b100001) return 0;
    if (op == 6'b000000 && fn == 6'b100011) return 1;
    if (op == 6'b001101) return 2;
    if (op == 6'b001111) return 3;
    if (op == 6'b100011) return 4;
    if (op == 6'b101011) return 5;
    if (op == 6'b000100) return 6;
    if (op == 6'b000010) return 7;
`ifdef MC_CTRL_JAL_EN
    if (op == 6'b000011) return 8;
`endif
    return 9;
  endfunction
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int waits,
                           input logic z, input int abort);
    out_t q[$];
    logic rdy[$];
    out_t o;
    int k;
    logic [1:0] e;
    logic s;
    string names[10] = '{"addu", "subu", "ori", "lui", "lw", "sw", "beq", "j", "jal", "ill"};
    k = classify(op, fn);
    o = '0; o.pc_wr = 1; o.ir_wr = 1;
    q.push_back(o); rdy.push_back(1'($urandom));
    o = '0; o.eop = 2'd3; o.illegal = k == 9;
    q.push_back(o); rdy.push_back(1'($urandom));
    if (k <= 5) begin
      e = k == 3 ? 2'd2 : k >= 4 ? 2'd1 : 2'd0;
      s = k >= 2;
      o = '0; o.eop = e; o.alu_srcb = s;
      o.alu_op = k == 1 ? 2'd1 : (k == 2 || k == 3) ? 2'd2 : 2'd0;
      q.push_back(o); rdy.push_back(1'($urandom));
      if (k >= 4)
        for (int w = 0; w <= waits; w++) begin
          o = '0; o.eop = e; o.alu_srcb = s;
          o.mem_rd = k == 4; o.mem_wr = k == 5; o.instr_done = k == 5 && w == waits;
          q.push_back(o); rdy.push_back(w == waits);
        end
      if (k != 5) begin
        o = '0; o.eop = e; o.alu_srcb = s; o.reg_wr = 1; o.instr_done = 1;
        o.reg_dst = k <= 1 ? 2'd1 : 2'd0; o.wd_sel = k == 4 ? 2'd1 : 2'd0;
        q.push_back(o); rdy.push_back(1'($urandom));
      end
    end else if (k == 6) begin
      o = '0; o.alu_op = 2'd1; o.npc_sel = 2'd1; o.pc_wr = z; o.instr_done = 1;
      q.push_back(o); rdy.push_back(1'($urandom));
    end else if (k == 7 || k == 8) begin
      o = '0; o.npc_sel = 2'd2; o.pc_wr = 1; o.instr_done = 1;
      if (k == 8) begin o.reg_wr = 1; o.reg_dst = 2'd2; o.wd_sel = 2'd2; end
      q.push_back(o); rdy.push_back(1'($urandom));
    end
    for (int i = 0; i < q.size(); i++) begin
      if (abort >= 0 && i == abort) return;
      @(negedge clk);
      opcode    = i < 2 ? op : 6'($urandom);
      funct     = i < 2 ? fn : 6'($urandom);
      mem_ready = rdy[i];
      zero      = (k == 6 && i == 2) ? z : 1'($urandom);
      #1;
      check($sformatf("%s c%0d", names[k], i), 32'(act), 32'(q[i]));
      check($sformatf("%s c%0d wr_excl", names[k], i), 32'(reg_wr & mem_wr), 32'd0);
    end
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("reset", 32'(act), 32'd0);
    end
    reset = 1'b1;
    #1 check("rst_release", 32'(act), 32'd0);
    run_instr(6'b001101, 6'd0, 0, 1'b0, -1);
    run_instr(6'b001111, 6'd0, 0, 1'b0, -1);
    run_instr(6'b100011, 6'd0, 2, 1'b0, -1);
    run_instr(6'b101011, 6'd0, 0, 1'b0, -1);
    run_instr(6'b000100, 6'd0, 0, 1'b1, -1);
    run_instr(6'b000100, 6'd0, 0, 1'b0, -1);
    run_instr(6'b111111, 6'd0, 0, 1'b0, -1);
    run_instr(6'b000011, 6'd0, 0, 1'b0, -1);
    run_instr(6'b000010, 6'd0, 0, 1'b0, -1);
    run_instr(6'b000000, 6'b100001, 0, 1'b0, -1);
    run_instr(6'b000000, 6'b100011, 0, 1'b0, -1);
    run_instr(6'b000000, 6'b000000, 0, 1'b0, -1);
    run_instr(6'b100011, 6'd0, 5, 1'b0, 5);
    reset = 1'b0;
    #1 check("async_rst_mem", 32'(act), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check("mid_reset", 32'(act), 32'd0);
    end
    reset = 1'b1;
    #1 check("mid_release", 32'(act), 32'd0);
    run_instr(6'b101011, 6'd0, 1, 1'b0, -1);
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op, fn;
      int r;
      r  = int'($urandom_range(0, 10));
      fn = 6'($urandom);
      case (r)
        0: begin op = 6'b000000; fn = 6'b100001; end
        1: begin op = 6'b000000; fn = 6'b100011; end
        2: op = 6'b001101;
        3: op = 6'b001111;
        4: op = 6'b100011;
        5: op = 6'b101011;
        6: op = 6'b000100;
        7: op = 6'b000010;
        8: op = 6'b000011;
        9: op = 6'b000000;
        default: op = 6'($urandom);
      endcase
      run_instr(op, fn, int'($urandom_range(0, 3)), 1'($urandom), -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
